fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch front end with a decoupled instruction queue. It owns the program counter and issues one sequential fetch per cycle to a fixed-latency (1-cycle) instruction memory. Returned words are buffered with their PC in a DEPTH-entry FIFO, and decode consumes them through a valid/ready handshake. A redirect (branch/jump) flushes the queue, drops the in-flight response and restarts fetch at the new PC in the same cycle.

## Interface
Parameters:
- INST_W, 24: instruction width in bits.
- PC_W, 32: PC/address width.
- DEPTH, 4: queue entries; legal range 2..16. Sustained 1 inst/cycle requires DEPTH >= 3.
- PC_STEP, 4: sequential PC increment.
- RESET_PC, 0: PC fetched first after reset.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: synchronous, active-high.
- redirect_en, in, 1: redirect request this cycle.
- redirect_pc, in, PC_W: target PC when redirect_en=1.
- imem_req, out, 1: fetch issued this cycle.
- imem_addr, out, PC_W: fetch address; combinational.
- imem_rdata, in, INST_W: data for the request issued in the previous cycle.
- out_valid, out, 1: queue head valid to decode.
- out_inst, out, INST_W: head instruction.
- out_pc, out, PC_W: PC of head instruction.
- out_ready, in, 1: decode accepts head this cycle.

## Operation
- Fetch address mux: imem_addr = redirect_en ? redirect_pc : fetch_pc.
- Issue condition: imem_req = !reset && (redirect_en || (count + req_q) < DEPTH).
  - req_q is the 1-bit in-flight flag.
  - Pop is deliberately excluded from the issue condition, so a push can never overflow the queue.
- On issue: fetch_pc <= imem_addr + PC_STEP (mod 2^PC_W, wraps silently), req_q <= 1, req_pc_q <= imem_addr.
- No issue: fetch_pc holds, req_q <= 0.
- Response: when req_q=1 and redirect_en=0, push {req_pc_q, imem_rdata} into the queue.
- Redirect cycle, in priority order:
  - queue flushed (count <= 0);
  - arriving response (req_q) dropped;
  - pop suppressed;
  - request to redirect_pc issued.
- Handshake:
  - out_valid = (count != 0) && !redirect_en.
  - Pop when out_valid && out_ready.
  - out_inst and out_pc are stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle: count unchanged; the FIFO handles a simultaneous push and pop in any state.
- Redirect has no state machine. Control state is only fetch_pc, req_q, req_pc_q, the FIFO pointers and count.

## Timing
- Reset (sampled high at an edge) forces:
  - fetch_pc=RESET_PC, req_q=0, count=0, FIFO pointers=0;
  - out_valid=0;
  - imem_req=0 while reset is high.
- Reset mid-operation discards all queued and in-flight words.
- Latency, with memory request in cycle N:
  - imem_rdata is valid in N+1 and pushed at the end of N+1;
  - out_valid=1 in N+2.
  - The first instruction after reset deassert appears 2 cycles after the first imem_req.
- Redirect in cycle R: imem_addr=redirect_pc in R, the target instruction is at the head in R+2, and no stale instruction is presented in R, R+1 or R+2.
- Full queue: imem_req=0 until count + req_q < DEPTH. Refill resumes in the cycle after the pop that frees space.
- Throughput: 1 instruction/cycle steady state for DEPTH >= 3 with out_ready held high.

## Structure
- Package fetch_pkg:
  - default constants for INST_W, PC_W, PC_STEP and RESET_PC;
  - typedef fetch_entry_t = {pc, inst} for the queue payload.
- Sub-module inst_fifo:
  - synchronous FIFO of fetch_entry_t, DEPTH entries, count output of $clog2(DEPTH+1) bits;
  - flush input with priority over push and pop;
  - registered storage with combinational head read.
- Top level holds the PC register, in-flight register, issue logic and redirect handling.

## Test plan
- Reset then free-run, memory returning word = address[23:0], out_ready=1: out_valid first rises 2 cycles after the first imem_req with out_pc=0, then pc 4, 8, 12… every cycle.
- Backpressure, DEPTH=4, out_ready=0 from reset:
  - exactly 4 requests issue (0, 4, 8, 12), then imem_req=0;
  - the head holds pc=0;
  - one pop (out_ready=1 for one cycle) leads to the next request at 16 in the following cycle.
- Redirect while streaming: at PC 0x20, pulse redirect_en with redirect_pc=0x100. out_valid=0 in the redirect cycle and the next cycle, the next delivered pc is 0x100, and 0x20/0x24 never appear.
- Redirect while full with out_ready=0: the queue empties, imem_addr=0x200 issues in the same cycle, and the head becomes pc=0x200 two cycles later.
- Reset asserted mid-stream with 3 entries queued: out_valid=0 the next cycle and fetch restarts at RESET_PC.
- Wrap: redirect_pc=2^PC_W-4 gives delivered pcs FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults and the queue payload type for the instruction-fetch front end.
package fetch_pkg;
  localparam int          INST_W_DEF   = 24;
  localparam int          PC_W_DEF     = 32;
  localparam int          PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// Synchronous DEPTH-entry FIFO with flush priority and a combinational head read.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           wdata_i,
  input  logic             pop_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    if (!flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues one sequential fetch per cycle to a
// 1-cycle memory and buffers returned words for decode; redirect flushes.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              INST_W   = INST_W_DEF,
  parameter int              PC_W     = PC_W_DEF,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = PC_STEP_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_en,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready
);
  localparam int              CNT_W = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] STEP  = PC_W'(PC_STEP);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             push, pop, flush;
  entry_t           push_entry, head;

  // Pop is left out of the occupancy test so a returning word always has a slot.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(req_q);
  assign imem_addr = redirect_en ? redirect_pc : fetch_pc_q;
  assign imem_req  = !reset && (redirect_en || (occupancy < (CNT_W + 1)'(DEPTH)));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = 1'b0;
    req_pc_d   = req_pc_q;
    if (reset) begin
      fetch_pc_d = RESET_PC;
    end else if (imem_req) begin
      fetch_pc_d = imem_addr + STEP;
      req_d      = 1'b1;
      req_pc_d   = imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    req_q      <= req_d;
    req_pc_q   <= req_pc_d;
  end

  assign flush      = reset || redirect_en;
  assign push       = req_q && !redirect_en;
  assign out_valid  = (count != '0) && !redirect_en;
  assign pop        = out_valid && out_ready;
  assign push_entry = '{pc: req_pc_q, inst: imem_rdata};

  inst_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign out_inst = head.inst;
  assign out_pc   = head.pc;
endmodule
